// File: rtl/mem_sum_master.sv
// mem_sum_master: reads a run of memory words, sums them and writes the total back (SUM_SAT_EN: saturating add)
module mem_sum_master #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] count,
  input  logic [AW-1:0] dst_addr,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] sum,
  output logic          ovf,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  localparam logic [AW-1:0] AMASK = ~AW'(3);
  state_t state;
  logic [AW-1:0] dst;
  logic [CW-1:0] rem;
  logic [DW-1:0] acc, add, nxt;
  logic of;
  always_comb begin
    add = acc + mem_rdata;
    of = (acc[DW-1] == mem_rdata[DW-1]) && (add[DW-1] != acc[DW-1]);
`ifdef SUM_SAT_EN
    nxt = of ? {acc[DW-1], {(DW-1){~acc[DW-1]}}} : add;
`else
    nxt = add;
`endif
  end
  // mem_addr doubles as the read pointer, so the address is valid in the same cycle as mem_rdata
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      sum <= '0;
      ovf <= 1'b0;
      dst <= '0;
      rem <= '0;
      acc <= '0;
    end else begin
      done <= state == WRITE;
      case (state)
        IDLE: if (start) begin
          state <= count != '0 ? READ : WRITE;
          busy <= 1'b1;
          dst <= dst_addr & AMASK;
          rem <= count;
          acc <= '0;
          ovf <= 1'b0;
          mem_addr <= (count != '0 ? base_addr : dst_addr) & AMASK;
          mem_we <= count == '0;
          if (count == '0) mem_wdata <= '0;
        end
        READ: begin
          acc <= nxt;
          ovf <= ovf | of;
          rem <= rem - 1'b1;
          mem_addr <= rem == CW'(1) ? dst : mem_addr + AW'(4);
          if (rem == CW'(1)) begin
            state <= WRITE;
            mem_we <= 1'b1;
            mem_wdata <= nxt;
          end
        end
        WRITE: begin
          state <= IDLE;
          busy <= 1'b0;
          mem_we <= 1'b0;
          sum <= acc;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_sum_master.sv
// tb_mem_sum_master: table-driven runs plus scoreboard of expected sums against a 32-word memory model
module tb_mem_sum_master;
  logic        clk, rst, start, busy, done, ovf, mem_we;
  logic [31:0] base_addr, dst_addr, sum, mem_addr, mem_wdata, mem_rdata;
  logic [5:0]  count;
  logic [31:0] mem [32];
  logic        ld;
  logic [4:0]  ld_a;
  logic [31:0] ld_d;
  int tests = 0, failed = 0;

  typedef struct {logic [31:0] sum; logic ovf; logic [4:0] idx;} exp_t;
  typedef struct {logic [31:0] base; logic [5:0] cnt; logic [31:0] dst; logic [31:0] esum; logic eovf;} vec_t;
  exp_t sb[$];
  vec_t vecs[5];

  localparam logic [31:0] POS_OVF =
`ifdef SUM_SAT_EN
    32'h7FFFFFFF;
`else
    32'h80000001;
`endif
  localparam logic [31:0] NEG_OVF =
`ifdef SUM_SAT_EN
    32'h80000000;
`else
    32'h00000000;
`endif

  mem_sum_master dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .dst_addr(dst_addr), .busy(busy), .done(done), .sum(sum), .ovf(ovf),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[6:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[6:2]] <= mem_wdata;
    else if (ld) mem[ld_a] <= ld_d;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [4:0] a, input logic [31:0] d);
    ld = 1'b1; ld_a = a; ld_d = d;
    @(negedge clk);
    ld = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 of the run.
  task automatic kick(input logic [31:0] b, input logic [5:0] c, input logic [31:0] d,
                      input logic [31:0] es, input logic eo, input bit push);
    logic [31:0] dd;
    dd = d;
    if (push) sb.push_back('{es, eo, dd[6:2]});
    start = 1'b1; base_addr = b; count = c; dst_addr = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int writes, output int bcyc);
    exp_t e;
    cyc = 1; writes = 0; bcyc = 0;
    while (!done && cyc < 200) begin
      if (mem_we) writes++;
      if (busy) bcyc++;
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      tests++; failed++;
      $display("FAIL done_timeout: no done within %0d cycles", cyc);
    end else if (sb.size() == 0) begin
      tests++; failed++;
      $display("FAIL scoreboard: done with no expected result queued");
    end else begin
      e = sb.pop_front();
      chk("sum", sum, e.sum);
      chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
      chk("mem_dst", mem[e.idx], e.sum);
    end
  endtask

  initial begin
    int cyc, wr, bc;
    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; dst_addr = '0;
    ld = 1'b0; ld_a = '0; ld_d = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_we", {31'd0, mem_we}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_sum", sum, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    rst = 1'b0;
    @(negedge clk);
    poke(5'h12, 32'h2); poke(5'h13, 32'hA3); poke(5'h14, 32'h27);
    poke(5'h15, 32'h79); poke(5'h16, 32'h115);
    poke(5'h1F, 32'h5); poke(5'h00, 32'h7); poke(5'h19, 32'hFFFF);

    vecs[0] = '{32'h48, 6'd5, 32'h60, 32'h25A, 1'b0};
    vecs[1] = '{32'h00, 6'd0, 32'h64, 32'h0,   1'b0};
    vecs[2] = '{32'h7C, 6'd2, 32'h68, 32'hC,   1'b0};
    vecs[3] = '{32'h4A, 6'd2, 32'h6F, 32'hA5,  1'b0};
    vecs[4] = '{32'h48, 6'd3, 32'h4C, 32'hCC,  1'b0};
    foreach (vecs[i]) begin
      kick(vecs[i].base, vecs[i].cnt, vecs[i].dst, vecs[i].esum, vecs[i].eovf, 1);
      wait_done(cyc, wr, bc);
      chk("latency", cyc, 32'(vecs[i].cnt) + 2);
      chk("writes", wr, 1);
      chk("busy_cycles", bc, 32'(vecs[i].cnt) + 1);
      chk("busy_at_done", {31'd0, busy}, 0);
    end
    poke(5'h13, 32'hA3);

    // read address wraps past word 31
    kick(32'h7C, 6'd2, 32'h6C, 32'hC, 1'b0, 1);
    chk("wrap_addr0", mem_addr, 32'h7C);
    @(negedge clk);
    chk("wrap_addr1", mem_addr, 32'h80);
    wait_done(cyc, wr, bc);

    // start while busy is ignored; start in the done cycle begins a new run
    poke(5'h1E, 32'h5A5A);
    kick(32'h48, 6'd3, 32'h74, 32'hCC, 1'b0, 1);
    start = 1'b1; base_addr = 32'h0; count = 6'd1; dst_addr = 32'h78;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, wr, bc);
    chk("ignored_writes", wr, 1);
    kick(32'h48, 6'd1, 32'h7C, 32'h2, 1'b0, 1);
    chk("done_pulse", {31'd0, done}, 0);
    chk("rerun_busy", {31'd0, busy}, 1);
    wait_done(cyc, wr, bc);
    chk("rerun_writes", wr, 1);
    chk("ignored_dst", mem[5'h1E], 32'h5A5A);

    // signed overflow, positive then negative
    poke(5'h13, 32'h7FFFFFFF);
    kick(32'h48, 6'd2, 32'h70, POS_OVF, 1'b1, 1);
    wait_done(cyc, wr, bc);
    poke(5'h14, 32'h80000000); poke(5'h15, 32'h80000000);
    kick(32'h50, 6'd2, 32'h74, NEG_OVF, 1'b1, 1);
    wait_done(cyc, wr, bc);

    // reset during READ aborts without writing
    poke(5'h10, 32'hDEAD);
    kick(32'h48, 6'd3, 32'h40, 32'h0, 1'b0, 0);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_we", {31'd0, mem_we}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_dst", mem[5'h10], 32'hDEAD);
    chk("abort_sum", sum, 0);
    kick(32'h48, 6'd1, 32'h40, 32'h2, 1'b0, 1);
    wait_done(cyc, wr, bc);
    chk("post_abort_lat", cyc, 3);

    // reset during WRITE drops mem_we immediately
    poke(5'h11, 32'hBEEF);
    kick(32'h0, 6'd0, 32'h44, 32'h0, 1'b0, 0);
    chk("write_we", {31'd0, mem_we}, 1);
    rst = 1'b1;
    #1;
    chk("write_abort_we", {31'd0, mem_we}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("write_abort_dst", mem[5'h11], 32'hBEEF);
    chk("write_abort_done", {31'd0, done}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
